stream_arb2: RTL
================

Name: stream_arb2

Overview:
- Two-input, packet-aware round-robin arbiter with valid/ready handshakes.
- Chooses which of two upstream streams is forwarded and generates the select for the existing 2:1 data mux.
- Registers the winning beat into a single output stage.
- Sits directly upstream of the consumer. A packet, delimited by `last`, is never interleaved with the other input.

Parameters:
- DATA_W, 8, width of each data beat.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in0_valid  input  1  stream 0 beat valid
- in0_data  input  DATA_W  stream 0 data
- in0_last  input  1  stream 0 final beat of packet
- in0_ready  output  1  stream 0 beat accepted this cycle
- in1_valid  input  1  stream 1 beat valid
- in1_data  input  DATA_W  stream 1 data
- in1_last  input  1  stream 1 final beat of packet
- in1_ready  output  1  stream 1 beat accepted this cycle
- out_valid  output  1  output beat valid (registered)
- out_data  output  DATA_W  output data (registered)
- out_last  output  1  output final beat (registered)
- out_src  output  1  source index of the current output beat (registered)
- out_ready  input  1  downstream accepts output beat

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - state=IDLE, prio=0 (input 0 favoured).
  - in0_ready=in1_ready=0 while reset is asserted.
- slot_free = !out_valid || out_ready. This is combinational, so a full output register still accepts a beat in the cycle it drains.
- States: IDLE (no packet open) and LOCK (packet open; owner register holds 0 or 1).
- IDLE grant (combinational):
  - Only one valid: that input wins.
  - Both valid: input `prio` wins.
  - winner_ready = slot_free; loser_ready = 0.
- LOCK grant: owner_ready = slot_free; the other input's ready = 0 regardless of its valid.
- Handshake: a beat transfers on an input when valid && ready. On transfer, the next cycle shows out_valid=1, out_data/out_last = the transferred beat, and out_src = its index. Latency is 1 cycle from acceptance to output.
- No transfer while slot_free: out_valid becomes 0 next cycle (output drains).
- No transfer while !slot_free: out_* hold and are stable while out_valid && !out_ready.
- Transitions:
  - IDLE → LOCK (owner=winner) when a non-last beat transfers.
  - IDLE stays IDLE when a last beat transfers, i.e. a single-beat packet.
  - LOCK stays LOCK on non-last owner beats.
  - LOCK → IDLE when the owner's last beat transfers.
- Round robin: on every transfer with last=1 from input i, prio ← ~i. prio is unchanged otherwise.
- Back-to-back packets: in IDLE, a new packet can transfer in the cycle after a last beat. With continuous valid on both inputs and out_ready=1, packets alternate sources with no bubble.
- Upstream rules checked by assertions in the bench:
  - valid, once raised, must not drop before ready.
  - data and last must be stable while valid && !ready.
  - The block itself guarantees the same rules on its output.
- Reset mid-packet: the open packet is abandoned; the block returns to IDLE with prio=0. Upstream owns any recovery.
- ready has no combinational dependency on in*_valid of the same input. It depends only on state, prio, the other input's valid (IDLE only), out_valid and out_ready.

Decomposition:
- Shared package/header:
  - state encoding constants ST_IDLE=1'b0, ST_LOCK=1'b1.
  - source index constants SRC0=1'b0, SRC1=1'b1.
- Sub-module: the data/last path select reuses the existing `mux2_1` cell, instantiated per bit (DATA_W+1 instances via generate) with select = granted index. Its output feeds the output register.
- Arbitration FSM and output register stay in stream_arb2.

Test Plan:
- Reset, then in0 sends single beat 0xA5 last=1 with out_ready=1 → in0_ready=1 that cycle; next cycle out_valid=1, out_data=0xA5, out_last=1, out_src=0.
- Both inputs valid with single-beat packets (in0=0x11, in1=0x22, repeating), out_ready=1 → output sequence 0x11,0x22,0x11,0x22 with out_src 0,1,0,1 and no idle cycles.
- in1 sends 3-beat packet 0x01,0x02,0x03(last) while in0 holds valid 0xFF from the second cycle → in0_ready=0 until 0x03 is accepted; output 0x01,0x02,0x03,0xFF.
- Drive out_ready=0 for 4 cycles after the first beat → out_valid=1 with out_data stable; both in*_ready=0; transfer resumes on the first out_ready=1 cycle with no beat lost or duplicated.
- Assert rst_n=0 mid-packet (after beat 2 of 4 from in0), asynchronous to clk → out_valid=0 immediately. After release, in1 sends 0x33 with both valid → in0 wins (prio=0).
- Random valid/ready, 10k cycles, scoreboard per source → every beat delivered in order, packets contiguous, output handshake stability holds.

Source files
------------

// File: rtl/stream_arb2_pkg.sv
// stream_arb2_pkg: shared encodings for the two-input packet arbiter.
//   state_e : arbitration state (ST_IDLE = no packet open, ST_LOCK = packet open)
//   SRC0/1  : source index values carried on out_src and used as mux select
package stream_arb2_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/stream_arb2_mux2_1.sv
// mux2_1: single-bit 2:1 mux cell.
//   a   : selected when sel = 0
//   b   : selected when sel = 1
//   sel : select
//   y   : output
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/stream_arb2.sv
// stream_arb2: two-input, packet-aware round-robin arbiter with one registered
// output stage. A packet (delimited by last) is never interleaved with the
// other input.
//   clk, rst_n                      : clock, async active-low reset
//   in0_valid/data/last, in0_ready  : upstream stream 0
//   in1_valid/data/last, in1_ready  : upstream stream 1
//   out_valid/data/last/src         : registered output beat and its source
//   out_ready                       : downstream accepts output beat
module stream_arb2
  import stream_arb2_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);

  state_e state_q;
  logic   owner_q;
  logic   prio_q;

  logic   slot_free;
  logic   xfer0, xfer1, xfer;
  logic   sel;
  logic [DATA_W:0] mux_a, mux_b, mux_y;

  // Output register can take a new beat in the same cycle it drains.
  assign slot_free = !out_valid || out_ready;

  // Ready never looks at the input's own valid; in IDLE it only looks at the
  // competing input's valid to decide whether prio has to break a tie.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (rst_n && slot_free) begin
      if (state_q == ST_LOCK) begin
        in0_ready = (owner_q == SRC0);
        in1_ready = (owner_q == SRC1);
      end else begin
        in0_ready = !in1_valid || (prio_q == SRC0);
        in1_ready = !in0_valid || (prio_q == SRC1);
      end
    end
  end

  assign xfer0 = in0_valid && in0_ready;
  assign xfer1 = in1_valid && in1_ready;
  assign xfer  = xfer0 || xfer1;

  // In IDLE at most one input can transfer, so xfer1 names the winner.
  assign sel = (state_q == ST_LOCK) ? owner_q : xfer1;

  assign mux_a = {in0_last, in0_data};
  assign mux_b = {in1_last, in1_data};

  for (genvar i = 0; i <= DATA_W; i++) begin : g_mux
    mux2_1 u_mux (
      .a  (mux_a[i]),
      .b  (mux_b[i]),
      .sel(sel),
      .y  (mux_y[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= SRC0;
      prio_q    <= SRC0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= SRC0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_y[DATA_W-1:0];
        out_last  <= mux_y[DATA_W];
        out_src   <= sel;
        if (mux_y[DATA_W]) begin
          // End of packet: release the lock and hand priority to the other side.
          state_q <= ST_IDLE;
          prio_q  <= ~sel;
        end else if (state_q == ST_IDLE) begin
          state_q <= ST_LOCK;
          owner_q <= sel;
        end
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
